// File: rtl/coarse_fifo_ctrl.sv
// Coarse-timing FIFO controller: keeps DELAY samples of history ahead of a
// sync point, then reads out one FRAME_LEN burst from the external FIFO.
`timescale 1ns/1ps
module coarse_fifo_ctrl #(
    parameter int DEPTH     = 220,
    parameter int DELAY     = 64,
    parameter int FRAME_LEN = 160
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    input  logic       sync_pulse,
    input  logic       out_ready,
    input  logic [8:0] fifo_count,
    input  logic       fifo_full,
    input  logic       fifo_empty,
    output logic       fifo_w_en,
    output logic       fifo_r_en,
    output logic       out_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       sync_miss,
    output logic       drop,
    output logic       abort,
    output logic [1:0] state
);

    localparam int RW = $clog2(FRAME_LEN + 1);
    localparam logic [8:0]    DELAY_C = 9'(DELAY);
    localparam logic [8:0]    DEPTH_C = 9'(DEPTH);
    localparam logic [RW-1:0] FRAME_C = RW'(FRAME_LEN);
    localparam logic [RW-1:0] ONE_C   = RW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PRIME = 2'b01,
        S_HOLD  = 2'b10,
        S_BURST = 2'b11
    } state_t;

    state_t        r_state;
    logic [RW-1:0] r_remaining;

    logic w_has_data;
    logic w_full;
    logic w_we;
    logic w_re;
    logic w_burst_rd;
    logic w_sync_take;

    // Both the count and the flag must agree before a read is allowed.
    assign w_has_data  = (fifo_count != 9'd0) && !fifo_empty;
    assign w_full      = fifo_full || (fifo_count >= DEPTH_C);
    assign w_sync_take = en && (r_state == S_HOLD) && sync_pulse;

    always_comb begin
        w_we       = 1'b0;
        w_re       = 1'b0;
        w_burst_rd = 1'b0;
        if (en) begin
            case (r_state)
                S_PRIME: begin
                    if (fifo_count < DELAY_C)
                        w_we = in_valid;
                    else if (fifo_count > DELAY_C)
                        w_re = w_has_data;
                end
                S_HOLD: begin
                    // Paired write/discard keeps the history window fixed.
                    w_we = in_valid;
                    w_re = in_valid && w_has_data;
                end
                S_BURST: begin
                    w_burst_rd = out_ready && w_has_data && (r_remaining != '0);
                    w_re       = w_burst_rd;
                    w_we       = in_valid && (!w_full || w_burst_rd);
                end
                default: ;
            endcase
        end
    end

    assign fifo_w_en = w_we && !rst;
    assign fifo_r_en = w_re && !rst;
    assign state     = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            sync_miss   <= 1'b0;
            drop        <= 1'b0;
            abort       <= 1'b0;
        end else begin
            out_valid   <= w_burst_rd;
            frame_start <= w_burst_rd && (r_remaining == FRAME_C);
            frame_end   <= w_burst_rd && (r_remaining == ONE_C);
            sync_miss   <= sync_pulse && !w_sync_take;
            drop        <= in_valid && !w_we;
            abort       <= 1'b0;
            if (!en) begin
                r_state     <= S_IDLE;
                r_remaining <= '0;
                abort       <= (r_state == S_BURST) && (r_remaining != '0);
            end else begin
                case (r_state)
                    S_IDLE:  r_state <= S_PRIME;
                    S_PRIME: if (fifo_count == DELAY_C) r_state <= S_HOLD;
                    S_HOLD: begin
                        if (sync_pulse) begin
                            r_state     <= S_BURST;
                            r_remaining <= FRAME_C;
                        end
                    end
                    S_BURST: begin
                        if (w_burst_rd) begin
                            r_remaining <= r_remaining - ONE_C;
                            if (r_remaining == ONE_C)
                                r_state <= S_PRIME;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/coarse_fifo_ctrl.md
COARSE_FIFO_CTRL -- requirements
Module: coarse_fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 220: capacity of the controlled coarse FIFO.
REQ-002 Parameter DELAY, default 64: history depth (samples) held ahead of a sync point.
REQ-003 Parameter FRAME_LEN, default 160: samples read out per burst.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 en  input  1  controller enable.
REQ-007 in_valid  input  1  new input sample present this cycle.
REQ-008 sync_pulse  input  1  coarse-timing detection strobe (one cycle).
REQ-009 out_ready  input  1  downstream accepts a sample.
REQ-010 fifo_count  input  9  FIFO occupancy (registered, FIFO side).
REQ-011 fifo_full / fifo_empty  input  1 each  FIFO flags.
REQ-012 fifo_w_en / fifo_r_en  output  1 each  combinational FIFO write/read enables.
REQ-013 out_valid  output  1  FIFO dout carries a burst sample this cycle.
REQ-014 frame_start / frame_end  output  1 each  pulse with first/last burst out_valid.
REQ-015 sync_miss  output  1  one-cycle pulse: sync_pulse ignored.
REQ-016 drop  output  1  one-cycle pulse: in_valid sample not written.
REQ-017 abort  output  1  one-cycle pulse: burst terminated early by en low.
REQ-018 state  output  2  IDLE=00, PRIME=01, HOLD=10, BURST=11.

Function
REQ-019 IDLE: w_en=r_en=0; in_valid drops; en=1 -> PRIME next cycle.
REQ-020 PRIME, fifo_count<DELAY: w_en=in_valid, r_en=0.
REQ-021 PRIME, fifo_count>DELAY: r_en=1 (discard), w_en=0; in_valid -> drop.
REQ-022 PRIME, fifo_count==DELAY: -> HOLD next cycle; w_en=r_en=0, in_valid -> drop.
REQ-023 HOLD: w_en=r_en=in_valid (paired write/discard-read); occupancy stays DELAY.
REQ-024 HOLD with sync_pulse: -> BURST next cycle; remaining counter loaded with FRAME_LEN.
REQ-025 sync_pulse in IDLE, PRIME or BURST: sync_miss pulse next cycle; no state change.
REQ-026 BURST: r_en = out_ready & (fifo_count!=0) & (remaining!=0); remaining decrements per r_en.
REQ-027 BURST: w_en = in_valid & (!fifo_full | r_en); otherwise in_valid -> drop.
REQ-028 r_en=1 SHALL never be issued with fifo_count==0 (FIFO reads regardless of empty on simultaneous w/r).
REQ-029 out_valid registered: high one cycle after each BURST r_en; read latency 1.
REQ-030 frame_start with out_valid of read 1; frame_end with out_valid of read FRAME_LEN.
REQ-031 Issue of read FRAME_LEN -> PRIME next cycle; PRIME trims excess per REQ-021.
REQ-032 en=0 in any state -> IDLE next cycle, enables 0 that cycle; in BURST with remaining!=0 -> abort pulse, no frame_end; already-issued read still gets out_valid.
REQ-033 remaining counter width ceil(log2(FRAME_LEN+1)); no wrap below 0.
REQ-034 drop/sync_miss/abort registered pulses, one cycle after the event.

Reset
REQ-035 rst=1: state=IDLE, remaining=0, out_valid, frame_start, frame_end, sync_miss, drop, abort=0; fifo_w_en=fifo_r_en=0 while rst high.
REQ-036 Reset mid-BURST: no frame_end or abort; IDLE on release, en=1 -> PRIME next cycle.

Verification
REQ-037 en=1, continuous in_valid, empty FIFO -> 64 writes, HOLD entered with fifo_count=64; HOLD keeps count 64 for 100 cycles.
REQ-038 HOLD, sync_pulse, out_ready=1, continuous in_valid -> exactly 160 out_valid; first sample = 64th before sync; frame_start/frame_end each once; then PRIME.
REQ-039 BURST, out_ready toggles 1/0, in_valid=0 -> reads stop at fifo_count=0, resume on new in_valid; total out_valid still 160; r_en never with count 0.
REQ-040 Post-burst count=150 -> PRIME discards 86 samples (drop on each in_valid) -> HOLD at count 64.
REQ-041 sync_pulse in PRIME -> sync_miss pulse, no BURST; en=0 after 50 burst reads -> abort, IDLE, out_valid count 50 (+1 if read in flight).
REQ-042 rst asserted mid-BURST -> all outputs 0 same cycle, state=00; no frame_end.
